// File: rtl/arp_pkg.sv
// arp_pkg: ARP request constants, FSM states and payload byte selection.
package arp_pkg;

    localparam logic [15:0] ARP_HTYPE        = 16'h0001;
    localparam logic [15:0] ARP_PTYPE        = 16'h0800;
    localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
    localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
    localparam logic [7:0]  ARP_HLEN         = 8'd6;
    localparam logic [7:0]  ARP_PLEN         = 8'd4;
    localparam int          ARP_PAYLOAD_LEN  = 28;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} arp_state_t;

    // Byte idx of the 28-byte request payload, MSB-first.
    function automatic logic [7:0] payload_byte(input logic [4:0] idx, input logic [47:0] sha,
                                                input logic [31:0] spa, input logic [31:0] tpa);
        logic [223:0] frame;
        frame = {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN, ARP_OPER_REQUEST, sha, spa, 48'd0, tpa}
                << {idx, 3'b000};
        return frame[223:216];
    endfunction

endpackage

// File: rtl/arp_request.sv
// arp_request: broadcasts ARP requests for a target IP and waits, with retries, for the reply.
module arp_request
    import arp_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR       = 48'hDEADBEEFCAFE,
    parameter logic [31:0] IP_ADDR        = 32'h69696969,
    parameter int          TIMEOUT_CYCLES = 125000000,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_tpa,
    output logic        tx_en,
    output logic [47:0] mac_dest,
    output logic [15:0] ethertype,
    input  logic        en,
    output logic        ovalid,
    output logic [7:0]  dout,
    input  logic        rsp_valid,
    input  logic [47:0] rsp_sha,
    input  logic [31:0] rsp_spa,
    output logic        res_valid,
    output logic        res_fail,
    output logic [47:0] res_mac
);

    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;

    arp_state_t    state, state_nxt;
    logic [4:0]    idx;
    logic [TW-1:0] timer;
    logic [RW-1:0] retries;
    logic [31:0]   tpa;
    logic          fail;
    logic          last, match, expired, can_retry;

    always_comb begin
        last      = state == SEND && en && idx == 5'(ARP_PAYLOAD_LEN - 1);
        match     = state == WAIT && rsp_valid && rsp_spa == tpa;
        expired   = state == WAIT && timer == TW'(TIMEOUT_CYCLES - 1);
        can_retry = retries < RW'(MAX_RETRIES);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = req_valid ? SEND : IDLE;
            SEND:    state_nxt = last ? WAIT : SEND;
            WAIT:    state_nxt = match ? DONE : expired ? (can_retry ? SEND : IDLE) : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            idx     <= '0;
            timer   <= '0;
            retries <= '0;
            tpa     <= '0;
            fail    <= 1'b0;
            res_mac <= '0;
        end else begin
            fail  <= 1'b0;
            timer <= state == WAIT ? timer + TW'(1) : '0;
            if (state == IDLE && req_valid) begin
                tpa     <= req_tpa;
                retries <= '0;
                idx     <= '0;
                res_mac <= '0;
            end
            if (state == SEND && en) idx <= last ? 5'd0 : idx + 5'd1;
            // A reply landing on the timeout cycle wins over the retry/fail path.
            if (match) res_mac <= rsp_sha;
            else if (expired) begin
                if (can_retry) retries <= retries + RW'(1);
                else fail <= 1'b1;
            end
        end

    always_comb begin
        req_ready = state == IDLE;
        tx_en     = state == SEND;
        ovalid    = tx_en;
        dout      = ovalid ? payload_byte(idx, MAC_ADDR, IP_ADDR, tpa) : 8'd0;
        mac_dest  = tx_en ? 48'hFFFFFFFFFFFF : 48'd0;
        ethertype = tx_en ? ETHERTYPE_ARP : 16'd0;
        res_valid = state == DONE;
        res_fail  = fail;
    end

endmodule

// File: tb/tb_arp_request.sv
// tb_arp_request: directed checks of arp_request framing, reply matching, retries and reset.
module tb_arp_request;

    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, en = 1'b0, rsp_valid = 1'b0;
    logic [31:0] req_tpa = '0, rsp_spa = '0;
    logic [47:0] rsp_sha = '0;
    logic        req_ready, tx_en, ovalid, res_valid, res_fail;
    logic [47:0] mac_dest, res_mac;
    logic [15:0] ethertype;
    logic [7:0]  dout;
    int          total = 0, bad = 0, c;

    localparam logic [7:0] HDR [18] = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
                                        8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE,
                                        8'h69, 8'h69, 8'h69, 8'h69};

    always #5 clk = ~clk;

    arp_request #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_tpa(req_tpa),
        .tx_en(tx_en), .mac_dest(mac_dest), .ethertype(ethertype), .en(en), .ovalid(ovalid),
        .dout(dout), .rsp_valid(rsp_valid), .rsp_sha(rsp_sha), .rsp_spa(rsp_spa),
        .res_valid(res_valid), .res_fail(res_fail), .res_mac(res_mac)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input logic [31:0] tpa);
        logic [31:0] t;
        if (i < 18) return HDR[i];
        if (i < 24) return 8'h00;
        t = tpa >> (8 * (27 - i));
        return t[7:0];
    endfunction

    // Called at a negedge in IDLE; returns at the first SEND negedge.
    task automatic do_req(input logic [31:0] tpa);
        chk("req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_tpa   = tpa;
        @(negedge clk);
        req_valid = 1'b0;
        chk("send_entry", tx_en, 1);
    endtask

    // Strobes en once every 'period' cycles and checks each consumed byte in order.
    task automatic send_frame(input string tag, input logic [31:0] tpa, input int period, input int nb);
        int n = 0, cyc = 0;
        while (n < nb && cyc < 500) begin
            en = (cyc % period) == 0;
            if (n == 0 && ovalid) begin
                chk({tag, "_mac_dest"}, mac_dest, 48'hFFFFFFFFFFFF);
                chk({tag, "_ethertype"}, ethertype, 16'h0806);
            end
            if (ovalid && en) begin
                chk($sformatf("%s_b%0d", tag, n), dout, exp_byte(n, tpa));
                n++;
            end
            cyc++;
            @(negedge clk);
        end
        en = 1'b0;
        chk({tag, "_len"}, n, nb);
        if (nb == 28) begin
            chk({tag, "_end_ovalid"}, ovalid, 0);
            chk({tag, "_end_dout"}, dout, 0);
        end
    endtask

    // From WAIT cycle 0, injects one reply at cycle 'at'; returns cycles until an outcome shows.
    task automatic wait_resp(input int at, input logic [31:0] spa, input logic [47:0] sha, output int cyc);
        cyc = 0;
        while (!(tx_en || res_fail || res_valid) && cyc < 60) begin
            rsp_valid = cyc == at;
            rsp_spa   = spa;
            rsp_sha   = sha;
            @(negedge clk);
            cyc++;
        end
        rsp_valid = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_tx_en", tx_en, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_mac_dest", mac_dest, 0);
        chk("rst_ethertype", ethertype, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_fail", res_fail, 0);
        chk("rst_res_mac", res_mac, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_req(32'h0A000002);
        send_frame("t1", 32'h0A000002, 1, 28);
        wait_resp(5, 32'h0A000002, 48'h112233445566, c);
        chk("t1_latency", c, 6);
        chk("t1_res_valid", res_valid, 1);
        chk("t1_res_mac", res_mac, 48'h112233445566);
        @(negedge clk);
        chk("t1_pulse_end", res_valid, 0);
        chk("t1_mac_held", res_mac, 48'h112233445566);

        do_req(32'h0A000002);
        for (int a = 0; a < 4; a++) begin
            send_frame($sformatf("t2f%0d", a), 32'h0A000002, a == 0 ? 3 : 1, 28);
            wait_resp(2, 32'h0A000003, 48'h112233445566, c);
            chk("t2_timeout", c, 16);
            chk("t2_resend", tx_en, a < 3);
            chk("t2_res_fail", res_fail, a == 3);
            chk("t2_no_res_valid", res_valid, 0);
        end
        @(negedge clk);
        chk("t2_fail_pulse_end", res_fail, 0);
        chk("t2_no_fifth", tx_en, 0);

        do_req(32'h0A000002);
        send_frame("t3", 32'h0A000002, 1, 28);
        wait_resp(15, 32'h0A000002, 48'h0A0B0C0D0E0F, c);
        chk("t3_latency", c, 16);
        chk("t3_res_valid", res_valid, 1);
        chk("t3_no_resend", tx_en, 0);
        chk("t3_res_mac", res_mac, 48'h0A0B0C0D0E0F);
        @(negedge clk);
        chk("t3_idle_tx", tx_en, 0);
        chk("t3_res_fail", res_fail, 0);

        do_req(32'h0A000005);
        send_frame("t4a", 32'h0A000005, 1, 10);
        chk("t4_byte10", dout, 8'hBE);
        #1 rst = 1'b0;
        #1;
        chk("t4_rst_ovalid", ovalid, 0);
        chk("t4_rst_tx_en", tx_en, 0);
        chk("t4_rst_dout", dout, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_after_tx_en", tx_en, 0);
        do_req(32'h0A000005);
        send_frame("t4b", 32'h0A000005, 1, 28);
        wait_resp(3, 32'h0A000005, 48'h665544332211, c);
        chk("t4_latency", c, 4);
        chk("t4_res_mac", res_mac, 48'h665544332211);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arp_request.md
ARP_REQUEST -- requirements
Module: arp_request

Interface
REQ-001 The module SHALL have parameter MAC_ADDR, default 48'hDEADBEEFCAFE, meaning the local sender hardware address.
REQ-002 The module SHALL have parameter IP_ADDR, default 32'h69696969, meaning the local sender protocol address.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 125000000, meaning the number of clk cycles to wait for a reply per attempt.
REQ-004 The module SHALL have parameter MAX_RETRIES, default 3, meaning the number of resends after the first attempt.
REQ-005 The module SHALL have the following ports, with one clock and an asynchronous active-low reset:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  resolve request.
- req_ready  out  1  high only in IDLE.
- req_tpa  in  32  target IP, sampled on handshake.
- tx_en  out  1  frame request to the RGMII transmitter.
- mac_dest  out  48  48'hFFFFFFFFFFFF while tx_en, else 0.
- ethertype  out  16  16'h0806 while tx_en, else 0.
- en  in  1  transmitter byte strobe (send_next).
- ovalid  out  1  dout holds a valid payload byte.
- dout  out  8  ARP payload byte.
- rsp_valid  in  1  one-cycle pulse: a decoded ARP frame is complete, already synchronous to clk.
- rsp_sha  in  48  decoded sender MAC.
- rsp_spa  in  32  decoded sender IP.
- res_valid  out  1  one-cycle pulse: resolution succeeded.
- res_fail  out  1  one-cycle pulse: retries exhausted.
- res_mac  out  48  resolved MAC, held until the next request.

Function
REQ-006 The state machine SHALL have the states IDLE, SEND, WAIT and DONE.
REQ-007 IDLE: when req_valid and req_ready are both high, the module SHALL latch req_tpa, clear the retry count and enter SEND on the next cycle.
REQ-008 SEND: tx_en SHALL be 1 and ovalid SHALL be 1, with dout equal to payload byte index 0..27.
REQ-009 A byte SHALL be consumed only on a cycle where en && ovalid; the index SHALL then advance and the next byte SHALL appear on dout the following cycle.
REQ-010 The payload SHALL be sent MSB-first in this order: 0001, 0800, 06, 04, 0001, MAC_ADDR, IP_ADDR, six 00 bytes, latched target IP; total 28 bytes.
REQ-011 The cycle after byte 27 is consumed, ovalid and tx_en SHALL be 0, the timer SHALL clear and the state SHALL become WAIT.
REQ-012 en SHALL be ignored outside SEND; dout SHALL be 0 whenever ovalid is 0.
REQ-013 WAIT: the timer SHALL increment every cycle.
REQ-014 WAIT: rsp_valid with rsp_spa equal to the latched target SHALL capture rsp_sha into res_mac and enter DONE.
REQ-015 WAIT: a non-matching rsp_valid SHALL be ignored.
REQ-016 When the timer reaches TIMEOUT_CYCLES-1 without a match and retries < MAX_RETRIES, the module SHALL increment retries, reset the byte index and re-enter SEND.
REQ-017 On timeout otherwise, the module SHALL pulse res_fail and return to IDLE.
REQ-018 A match and a timeout in the same cycle SHALL resolve as a match.
REQ-019 rsp_valid SHALL be ignored in IDLE, SEND and DONE.
REQ-020 DONE SHALL pulse res_valid for exactly one cycle and then return to IDLE.
REQ-021 Latency from the last byte strobe to res_valid SHALL be the reply arrival cycle + 2.
REQ-022 The byte index SHALL be 5 bits and never exceed 27.
REQ-023 The timer width SHALL be $clog2(TIMEOUT_CYCLES).
REQ-024 The retry counter width SHALL be $clog2(MAX_RETRIES+1), with no wrap.

Reset
REQ-025 rst low SHALL asynchronously force state IDLE and zero all counters.
REQ-026 rst low SHALL asynchronously force tx_en, ovalid, dout, mac_dest, ethertype, res_valid, res_fail and res_mac to 0, and req_ready to 1 after release.
REQ-027 Reset during SEND SHALL truncate the frame immediately, with no further bytes offered.

Structure
REQ-028 Package arp_pkg SHALL hold the constants ARP_HTYPE, ARP_PTYPE, ARP_OPER_REQUEST, ETHERTYPE_ARP, ARP_PAYLOAD_LEN=28 and the state enum.
REQ-029 The payload byte selection SHALL be a combinational function in arp_pkg; no sub-module SHALL be used.

Verification
REQ-030 Request tpa=0A000002 with en held high -> 28 bytes: 00 01 08 00 06 04 00 01 DE AD BE EF CA FE 69 69 69 69 00x6 0A 00 00 02, mac_dest all-FF, ethertype 0806.
REQ-031 en toggling 1-in-3 -> identical byte sequence, with no byte duplicated or skipped.
REQ-032 TIMEOUT_CYCLES=16, reply spa=0A000002 sha=112233445566 at WAIT cycle 5 -> res_valid one cycle, res_mac=112233445566.
REQ-033 Reply spa=0A000003 only -> ignored; 4 frames sent in total, then res_fail pulse.
REQ-034 Matching reply on the exact timeout cycle -> res_valid, and no resend.
REQ-035 rst low at byte 10 -> ovalid/tx_en 0 immediately, req_ready 1 after release, and the next request restarts at byte 0.
